pixel_write_sink: RTL

//  Receiving end of the raycaster pixel-write stream (write_en/addr/word0-2 + frame_done).

---
 rtl/pixel_write_sink.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pixel_write_sink.sv
// Sink for the raycaster pixel-write stream: buffers writes in a FWFT FIFO for the host port
// and re-times frame_done so frame_out fires only once that frame's pixels have drained.
module pixel_write_sink #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_write_en,
    input  logic [ADDR_WIDTH-1:0]         in_addr,
    input  logic [31:0]                   in_word0,
    input  logic [31:0]                   in_word1,
    input  logic [31:0]                   in_word2,
    input  logic                          in_frame_done,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic [31:0]                   out_word0,
    output logic [31:0]                   out_word1,
    output logic [31:0]                   out_word2,
    output logic                          frame_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   overflow_count,
    output logic [CNT_WIDTH-1:0]          last_frame_pixels,
    output logic [CNT_WIDTH-1:0]          frame_count
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + 96;
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_PULSE} state_t;

    logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;
    logic [LVL_W-1:0]     remaining_q, remaining_d;
    logic [15:0]          ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_WIDTH-1:0] last_pix_q, last_pix_d;
    logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
    state_t               state_q, state_d;
    logic                 push, pop;
    logic [ENTRY_W-1:0]   head;

    always_comb begin
        pop      = (level_q != '0) && out_ready;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        push     = in_write_en && ((level_q != DEPTH_LVL) || pop);
        level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        ovf_d    = ovf_q;
        if (in_write_en && !push && (ovf_q != 16'hFFFF)) begin
            ovf_d = ovf_q + 16'd1;
        end
        pix_cnt_d  = pix_cnt_q + CNT_WIDTH'(push);
        last_pix_d = last_pix_q;
        if (in_frame_done) begin
            last_pix_d = pix_cnt_q + CNT_WIDTH'(push);
            pix_cnt_d  = '0;
        end
        frame_cnt_d = frame_cnt_q + CNT_WIDTH'(state_q == ST_PULSE);
        head        = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_addr, in_word0, in_word1, in_word2};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            remaining_q <= '0;
            ovf_q       <= '0;
            pix_cnt_q   <= '0;
            last_pix_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            remaining_q <= remaining_d;
            ovf_q       <= ovf_d;
            pix_cnt_q   <= pix_cnt_d;
            last_pix_q  <= last_pix_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // remaining counts entries ahead of the frame boundary; going straight to PULSE
    // when it hits zero puts frame_out one cycle after the last pop of the frame.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        unique case (state_q)
            ST_RUN: begin
                if (in_frame_done) begin
                    remaining_d = level_d;
                    state_d     = (level_d == '0) ? ST_PULSE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (remaining_q == '0) begin
                    state_d = ST_PULSE;
                end else begin
                    remaining_d = remaining_q - LVL_W'(pop);
                    if (remaining_d == '0) begin
                        state_d = ST_PULSE;
                    end
                end
            end
            ST_PULSE: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        frame_out = (state_q == ST_PULSE);
        out_valid = (level_q != '0);
        {out_addr, out_word0, out_word1, out_word2} = out_valid ? head : '0;
        fifo_level        = level_q;
        overflow_count    = ovf_q;
        last_frame_pixels = last_pix_q;
        frame_count       = frame_cnt_q;
    end

endmodule
